// File: rtl/tcdm_error_slave_mc.sv
// Multi-channel TCDM error slave: grants every request, answers each one with an
// error response after a fixed latency, and logs the first fault plus a fault count.
module tcdm_error_slave_mc #(
    parameter int unsigned                  NB_CH          = 2,
    parameter int unsigned                  ADDR_WIDTH     = 32,
    parameter int unsigned                  DATA_WIDTH     = 32,
    parameter logic [DATA_WIDTH-1:0]        ERROR_RESPONSE = DATA_WIDTH'(32'hBADACCE5),
    parameter int unsigned                  RESP_LATENCY   = 1,
    parameter int unsigned                  CNT_WIDTH      = 16
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    input  logic [NB_CH-1:0]                              req_i,
    input  logic [NB_CH*ADDR_WIDTH-1:0]                   add_i,
    input  logic [NB_CH-1:0]                              wen_i,
    output logic [NB_CH-1:0]                              gnt_o,
    output logic [NB_CH-1:0]                              r_valid_o,
    output logic [NB_CH*DATA_WIDTH-1:0]                   r_rdata_o,
    output logic [NB_CH-1:0]                              r_opc_o,
    input  logic                                          clear_i,
    output logic [ADDR_WIDTH-1:0]                         err_addr_o,
    output logic [((NB_CH > 1) ? $clog2(NB_CH) : 1)-1:0]  err_chan_o,
    output logic                                          err_write_o,
    output logic [CNT_WIDTH-1:0]                          err_count_o,
    output logic                                          err_ovf_o,
    output logic                                          err_irq_o
);

    localparam int unsigned CHW  = (NB_CH > 1) ? $clog2(NB_CH) : 1;
    localparam int unsigned PCW  = $clog2(NB_CH + 1);
    localparam int unsigned SUMW = CNT_WIDTH + PCW;
    localparam logic [SUMW-1:0] CNT_MAX = SUMW'({CNT_WIDTH{1'b1}});

    typedef enum logic {IDLE, LOGGED} state_e;

    // ---------------- response pipeline ----------------
    logic [NB_CH-1:0] pipe_q [RESP_LATENCY];
    logic [NB_CH-1:0] pipe_d [RESP_LATENCY];

    assign gnt_o = req_i;

    always_comb begin
        for (int s = 0; s < int'(RESP_LATENCY); s++) begin
            pipe_d[s] = '0;
        end
        pipe_d[0] = req_i;
        for (int s = 1; s < int'(RESP_LATENCY); s++) begin
            pipe_d[s] = pipe_q[s-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < int'(RESP_LATENCY); s++) begin
                pipe_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < int'(RESP_LATENCY); s++) begin
                pipe_q[s] <= pipe_d[s];
            end
        end
    end

    assign r_valid_o = pipe_q[RESP_LATENCY-1];
    assign r_opc_o   = pipe_q[RESP_LATENCY-1];

    always_comb begin
        r_rdata_o = '0;
        for (int i = 0; i < int'(NB_CH); i++) begin
            if (r_valid_o[i]) begin
                r_rdata_o[i*DATA_WIDTH +: DATA_WIDTH] = ERROR_RESPONSE;
            end
        end
    end

    // ---------------- error log ----------------
    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CHW-1:0]        chan_q, chan_d;
    logic                  write_q, write_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic                  ovf_q, ovf_d;

    logic [PCW-1:0]        pop;
    logic [ADDR_WIDTH-1:0] cap_addr;
    logic [CHW-1:0]        cap_chan;
    logic                  cap_write;
    state_e                base_state;
    logic [SUMW-1:0]       sum;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        chan_d    = chan_q;
        write_d   = write_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        pop       = '0;
        cap_addr  = '0;
        cap_chan  = '0;
        cap_write = 1'b0;

        // Descending scan so the lowest-indexed requester wins the capture.
        for (int i = int'(NB_CH) - 1; i >= 0; i--) begin
            pop = pop + PCW'(req_i[i]);
            if (req_i[i]) begin
                cap_addr  = add_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                cap_write = ~wen_i[i];
                cap_chan  = CHW'(i);
            end
        end

        // Clear takes effect first; a same-cycle request is then logged afresh.
        base_state = state_q;
        if (clear_i) begin
            base_state = IDLE;
            addr_d     = '0;
            chan_d     = '0;
            write_d    = 1'b0;
            count_d    = '0;
            ovf_d      = 1'b0;
        end
        state_d = base_state;

        sum = SUMW'(count_d) + SUMW'(pop);
        count_d = (sum > CNT_MAX) ? CNT_WIDTH'(CNT_MAX) : CNT_WIDTH'(sum);

        if (|req_i) begin
            if (base_state == IDLE) begin
                state_d = LOGGED;
                addr_d  = cap_addr;
                chan_d  = cap_chan;
                write_d = cap_write;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            addr_q  <= '0;
            chan_q  <= '0;
            write_q <= 1'b0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            chan_q  <= chan_d;
            write_q <= write_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign err_addr_o  = addr_q;
    assign err_chan_o  = chan_q;
    assign err_write_o = write_q;
    assign err_count_o = count_q;
    assign err_ovf_o   = ovf_q;
    assign err_irq_o   = (state_q == LOGGED);

endmodule

// File: tb/tb_tcdm_error_slave_mc.sv
// Directed bench for tcdm_error_slave_mc: three instances (latency 1/3/2, one with a
// 4-bit counter) share one stimulus stream.
module tb_tcdm_error_slave_mc;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic [1:0]  req;
    logic [63:0] add;
    logic [1:0]  wen;
    logic        clear;

    logic [1:0]  gnt_a, rv_a, opc_a;
    logic [63:0] rdata_a;
    logic [31:0] eaddr_a;
    logic [0:0]  echan_a;
    logic        ewr_a, eovf_a, eirq_a;
    logic [15:0] ecnt_a;

    logic [1:0]  gnt_b, rv_b, opc_b;
    logic [63:0] rdata_b;
    logic [31:0] eaddr_b;
    logic [0:0]  echan_b;
    logic        ewr_b, eovf_b, eirq_b;
    logic [3:0]  ecnt_b;

    logic [1:0]  gnt_c, rv_c, opc_c;
    logic [63:0] rdata_c;
    logic [31:0] eaddr_c;
    logic [0:0]  echan_c;
    logic        ewr_c, eovf_c, eirq_c;
    logic [15:0] ecnt_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tcdm_error_slave_mc #(.NB_CH(2), .RESP_LATENCY(1), .CNT_WIDTH(16)) dut_a (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .add_i(add), .wen_i(wen),
        .gnt_o(gnt_a), .r_valid_o(rv_a), .r_rdata_o(rdata_a), .r_opc_o(opc_a),
        .clear_i(clear), .err_addr_o(eaddr_a), .err_chan_o(echan_a), .err_write_o(ewr_a),
        .err_count_o(ecnt_a), .err_ovf_o(eovf_a), .err_irq_o(eirq_a));

    tcdm_error_slave_mc #(.NB_CH(2), .RESP_LATENCY(3), .CNT_WIDTH(4)) dut_b (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .add_i(add), .wen_i(wen),
        .gnt_o(gnt_b), .r_valid_o(rv_b), .r_rdata_o(rdata_b), .r_opc_o(opc_b),
        .clear_i(clear), .err_addr_o(eaddr_b), .err_chan_o(echan_b), .err_write_o(ewr_b),
        .err_count_o(ecnt_b), .err_ovf_o(eovf_b), .err_irq_o(eirq_b));

    tcdm_error_slave_mc #(.NB_CH(2), .RESP_LATENCY(2), .CNT_WIDTH(16)) dut_c (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .add_i(add), .wen_i(wen),
        .gnt_o(gnt_c), .r_valid_o(rv_c), .r_rdata_o(rdata_c), .r_opc_o(opc_c),
        .clear_i(clear), .err_addr_o(eaddr_c), .err_chan_o(echan_c), .err_write_o(ewr_c),
        .err_count_o(ecnt_c), .err_ovf_o(eovf_c), .err_irq_o(eirq_c));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        req   = 2'b00;
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        rst_ni = 1'b0;
        req    = 2'b00;
        add    = '0;
        wen    = 2'b11;
        clear  = 1'b0;
        repeat (2) tick();

        // reset state and combinational grant during reset
        check("rst_rvalid_a", 64'(rv_a), 64'h0);
        check("rst_opc_b",    64'(opc_b), 64'h0);
        check("rst_count_a",  64'(ecnt_a), 64'h0);
        check("rst_irq_a",    64'(eirq_a), 64'h0);
        check("rst_addr_a",   64'(eaddr_a), 64'h0);
        req = 2'b01;
        #1;
        check("rst_gnt_a", 64'(gnt_a), 64'h1);
        req = 2'b00;
        #1;
        rst_ni = 1'b1;
        tick();

        // single read on ch0, latency 1
        req = 2'b01;
        add[31:0] = 32'h1A10_0004;
        wen = 2'b11;
        #1;
        check("t1_gnt_same_cycle", 64'(gnt_a), 64'h1);
        check("t1_rvalid_before", 64'(rv_a), 64'h0);
        tick();
        req = 2'b00;
        check("t1_rvalid",  64'(rv_a), 64'h1);
        check("t1_opc",     64'(opc_a), 64'h1);
        check("t1_rdata0",  64'(rdata_a[31:0]), 64'hBADACCE5);
        check("t1_rdata1",  64'(rdata_a[63:32]), 64'h0);
        check("t1_addr",    64'(eaddr_a), 64'h1A10_0004);
        check("t1_chan",    64'(echan_a), 64'h0);
        check("t1_write",   64'(ewr_a), 64'h0);
        check("t1_count",   64'(ecnt_a), 64'h1);
        check("t1_irq",     64'(eirq_a), 64'h1);
        check("t1_ovf",     64'(eovf_a), 64'h0);
        tick();
        check("t1_rvalid_drop", 64'(rv_a), 64'h0);
        check("t1_rdata_zero",  64'(rdata_a), 64'h0);
        do_clear();
        check("clr_count_a", 64'(ecnt_a), 64'h0);
        check("clr_irq_a",   64'(eirq_a), 64'h0);
        check("clr_addr_a",  64'(eaddr_a), 64'h0);
        repeat (3) tick();

        // four back-to-back writes on ch1, latency 3 on dut_b
        req = 2'b10;
        wen = 2'b01;
        add[63:32] = 32'h2000_0008;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check($sformatf("t2_rvalid_b_k%0d", k), 64'(rv_b),
                  (k >= 3 && k <= 6) ? 64'h2 : 64'h0);
            if (k == 4) req = 2'b00;
        end
        check("t2_count_b", 64'(ecnt_b), 64'h4);
        check("t2_ovf_b",   64'(eovf_b), 64'h1);
        check("t2_write_b", 64'(ewr_b), 64'h1);
        check("t2_chan_b",  64'(echan_b), 64'h1);
        check("t2_addr_b",  64'(eaddr_b), 64'h2000_0008);
        check("t2_count_a", 64'(ecnt_a), 64'h4);
        wen = 2'b11;
        do_clear();
        repeat (3) tick();

        // simultaneous requests from IDLE
        req = 2'b11;
        add = {32'h0000_0020, 32'h0000_0010};
        tick();
        req = 2'b00;
        check("t3_chan",  64'(echan_a), 64'h0);
        check("t3_addr",  64'(eaddr_a), 64'h10);
        check("t3_count", 64'(ecnt_a), 64'h2);
        check("t3_ovf",   64'(eovf_a), 64'h0);
        check("t3_rvalid", 64'(rv_a), 64'h3);
        do_clear();
        repeat (3) tick();

        // counter saturation on the 4-bit instance
        req = 2'b01;
        repeat (14) tick();
        check("t4_count_b_14", 64'(ecnt_b), 64'd14);
        repeat (6) tick();
        check("t4_count_b_sat", 64'(ecnt_b), 64'd15);
        check("t4_count_a_20",  64'(ecnt_a), 64'd20);
        check("t4_ovf_a",       64'(eovf_a), 64'h1);

        // clear together with a ch1 request
        clear = 1'b1;
        req   = 2'b10;
        add[63:32] = 32'h0000_0100;
        tick();
        clear = 1'b0;
        req   = 2'b00;
        check("t5_irq",   64'(eirq_a), 64'h1);
        check("t5_addr",  64'(eaddr_a), 64'h100);
        check("t5_chan",  64'(echan_a), 64'h1);
        check("t5_count", 64'(ecnt_a), 64'h1);
        check("t5_ovf",   64'(eovf_a), 64'h0);
        check("t5_rvalid_b_inflight", 64'(rv_b), 64'h1);
        do_clear();
        check("t5_clear_irq", 64'(eirq_a), 64'h0);
        repeat (3) tick();

        // reset with two responses in flight on the latency-2 instance
        req = 2'b11;
        tick();
        req = 2'b00;
        check("t6_rvalid_c_pre", 64'(rv_c), 64'h0);
        rst_ni = 1'b0;
        #1;
        check("t6_rst_rvalid_c", 64'(rv_c), 64'h0);
        check("t6_rst_count_c",  64'(ecnt_c), 64'h0);
        check("t6_rst_irq_c",    64'(eirq_c), 64'h0);
        tick();
        rst_ni = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check($sformatf("t6_post_rvalid_c_k%0d", k), 64'(rv_c), 64'h0);
        end
        check("t6_addr_c",  64'(eaddr_c), 64'h0);
        check("t6_chan_c",  64'(echan_c), 64'h0);
        check("t6_write_c", 64'(ewr_c), 64'h0);
        check("t6_ovf_c",   64'(eovf_c), 64'h0);
        check("t6_opc_c",   64'(opc_c), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
